// File: rtl/timer_multi.sv
// timer_multi: multi-channel prescaler/rounds timer with sticky done flags and a combined registered irq
module timer_multi #(
  parameter int WIDTH = 16,
  parameter int CH_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               we,
  input  logic [CH_BITS+2:0] addr,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  output logic               irq
);
  localparam int CHANNELS = 2 ** CH_BITS;
  logic [WIDTH-1:0] presc_q [CHANNELS];
  logic [WIDTH-1:0] presc_d [CHANNELS];
  logic [WIDTH-1:0] rounds_q [CHANNELS];
  logic [WIDTH-1:0] rounds_d [CHANNELS];
  logic [WIDTH-1:0] pgoal_q [CHANNELS];
  logic [WIDTH-1:0] pgoal_d [CHANNELS];
  logic [WIDTH-1:0] rgoal_q [CHANNELS];
  logic [WIDTH-1:0] rgoal_d [CHANNELS];
  logic [WIDTH-1:0] rnext [CHANNELS];
  logic [CHANNELS-1:0] run_q, run_d, done_q, done_d, per_q, per_d, ien_q, ien_d;
  logic [CHANNELS-1:0] hit, start, adv, tick, fin;
  logic irq_q, irq_d;
  logic [2:0] sel;
  logic [CH_BITS-1:0] ch;
  logic [WIDTH-1:0] rd;
  assign sel = addr[2:0];
  assign ch = addr[CH_BITS+2:3];
  always_comb begin
    presc_d = presc_q;
    rounds_d = rounds_q;
    pgoal_d = pgoal_q;
    rgoal_d = rgoal_q;
    rnext = rounds_q;
    run_d = run_q;
    done_d = done_q;
    per_d = per_q;
    ien_d = ien_q;
    hit = '0;
    start = '0;
    adv = '0;
    tick = '0;
    fin = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = cs && we && ch == CH_BITS'(c);
      start[c] = hit[c] && sel == 3'd2 && in[0];
      adv[c] = run_q[c] && !(hit[c] && sel == 3'd2 && in[1]);
      tick[c] = adv[c] && presc_q[c] == pgoal_q[c];
      rnext[c] = rounds_q[c] + WIDTH'(1);
      fin[c] = tick[c] && rnext[c] == rgoal_q[c];
      presc_d[c] = !adv[c] ? presc_q[c] : tick[c] ? '0 : presc_q[c] + WIDTH'(1);
      rounds_d[c] = fin[c] && per_q[c] ? '0 : tick[c] ? rnext[c] : rounds_q[c];
      run_d[c] = (fin[c] ? per_q[c] : adv[c]) && !(hit[c] && sel < 3'd2);
      done_d[c] = fin[c] || (done_q[c] && !(hit[c] && sel == 3'd3 && in[0]));
      rgoal_d[c] = hit[c] && sel == 3'd0 ? in : rgoal_q[c];
      pgoal_d[c] = hit[c] && sel == 3'd1 ? in : pgoal_q[c];
      per_d[c] = hit[c] && sel == 3'd2 ? in[2] : per_q[c];
      ien_d[c] = hit[c] && sel == 3'd2 ? in[3] : ien_q[c];
      if (start[c]) begin
        presc_d[c] = '0;
        rounds_d[c] = '0;
        done_d[c] = rgoal_q[c] == '0;
        run_d[c] = rgoal_q[c] != '0;
      end
    end
    irq_d = |(done_q & ien_q);
  end
  assign rd = sel == 3'd0 ? rgoal_q[ch] :
              sel == 3'd1 ? pgoal_q[ch] :
              sel == 3'd2 ? WIDTH'({run_q[ch], ien_q[ch], per_q[ch], 2'b00}) :
              sel == 3'd3 ? WIDTH'({run_q[ch], done_q[ch]}) :
              sel == 3'd4 ? rounds_q[ch] : '0;
  assign out = cs && !we ? rd : '0;
  assign irq = irq_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        presc_q[c] <= '0;
        rounds_q[c] <= '0;
        pgoal_q[c] <= '0;
        rgoal_q[c] <= '0;
      end
      run_q <= '0;
      done_q <= '0;
      per_q <= '0;
      ien_q <= '0;
      irq_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      rounds_q <= rounds_d;
      pgoal_q <= pgoal_d;
      rgoal_q <= rgoal_d;
      run_q <= run_d;
      done_q <= done_d;
      per_q <= per_d;
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: vector table, directed timing sequences and random traffic checked against a behavioural model
module tb_timer_multi;
  logic clk = 1'b0, reset = 1'b0, cs = 1'b0, we = 1'b0;
  logic [3:0] addr = '0;
  logic [15:0] din = '0, dout, rd;
  logic irq;
  int n_chk = 0, n_err = 0, t = 0;
  int m_rg[2], m_pg[2], m_start[2], m_frz[2];
  bit m_run[2], m_per[2], m_ien[2], m_done[2], m_irq;

  typedef struct {
    logic        we;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] want;
  } vec_t;
  vec_t tbl[$];

  timer_multi #(.WIDTH(16), .CH_BITS(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .in(din), .out(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Elapsed-time view: while running, rounds is simply completed ticks since the (re)start.
  function automatic int rounds_at(input int k, input int tt);
    if (!m_run[k]) return m_frz[k];
    return (tt - m_start[k]) / (m_pg[k] + 1);
  endfunction

  function automatic logic [15:0] exp_read(input logic [3:0] a);
    int k;
    k = int'(a[3]);
    case (a[2:0])
      3'd0: return 16'(m_rg[k]);
      3'd1: return 16'(m_pg[k]);
      3'd2: return {11'd0, m_run[k], m_ien[k], m_per[k], 2'b00};
      3'd3: return {14'd0, m_run[k], m_done[k]};
      3'd4: return 16'(rounds_at(k, t));
      default: return 16'h0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rg[k] = 0; m_pg[k] = 0; m_start[k] = 0; m_frz[k] = 0;
      m_run[k] = 0; m_per[k] = 0; m_ien[k] = 0; m_done[k] = 0;
    end
    m_irq = 0;
  endfunction

  function automatic void model_edge(input logic c, input logic w, input logic [3:0] a, input logic [15:0] d);
    bit nirq;
    nirq = 0;
    for (int k = 0; k < 2; k++) nirq |= m_done[k] & m_ien[k];
    t++;
    for (int k = 0; k < 2; k++) begin
      bit hit, ctrl, ev;
      int e, plen;
      hit = c && w && (a[3] == k[0]);
      ctrl = hit && a[2:0] == 3'd2;
      ev = 0;
      if (m_run[k] && ctrl && d[1] && !d[0]) begin
        m_frz[k] = rounds_at(k, t - 1);
        m_run[k] = 0;
      end else if (m_run[k]) begin
        e = t - m_start[k];
        plen = m_rg[k] * (m_pg[k] + 1);
        if (e == plen) begin
          ev = 1;
          m_done[k] = 1;
          if (m_per[k]) m_start[k] = t;
          else begin
            m_run[k] = 0;
            m_frz[k] = m_rg[k];
          end
        end
      end
      if (hit && a[2:0] == 3'd3 && d[0] && !ev) m_done[k] = 0;
      if (hit && a[2:0] < 3'd2) begin
        if (m_run[k]) begin
          m_frz[k] = rounds_at(k, t);
          m_run[k] = 0;
        end
        if (a[2:0] == 3'd0) m_rg[k] = int'(d);
        else m_pg[k] = int'(d);
      end
      if (ctrl) begin
        m_per[k] = d[2];
        m_ien[k] = d[3];
      end
      if (ctrl && d[0]) begin
        m_start[k] = t;
        m_run[k] = m_rg[k] != 0;
        m_done[k] = m_rg[k] == 0;
        m_frz[k] = 0;
      end
    end
    m_irq = nirq;
  endfunction

  task automatic step(input logic c, input logic w, input logic [3:0] a, input logic [15:0] d);
    cs = c; we = w; addr = a; din = d;
    #2 rd = dout;
    chk("out", rd, (c && !w) ? exp_read(a) : 16'h0);
    @(posedge clk);
    model_edge(c, w, a, d);
    #1 chk("irq", irq, m_irq);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cs = 1'b0; we = 1'b0;
    @(posedge clk);
    model_reset();
    #1 reset = 1'b0;
    chk("irq_rst", irq, 0);
  endtask

  initial begin
    logic kb;
    int op;
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 4'(i), 16'h0, 16'h0});
    tbl.push_back('{1'b1, 4'h0, 16'h1234, 16'h0});
    tbl.push_back('{1'b0, 4'h0, 16'h0, 16'h1234});
    tbl.push_back('{1'b1, 4'h9, 16'hbeef, 16'h0});
    tbl.push_back('{1'b0, 4'h9, 16'h0, 16'hbeef});
    tbl.push_back('{1'b0, 4'h1, 16'h0, 16'h0});
    tbl.push_back('{1'b0, 4'h8, 16'h0, 16'h0});
    tbl.push_back('{1'b1, 4'hd, 16'hffff, 16'h0});
    tbl.push_back('{1'b0, 4'hd, 16'h0, 16'h0});
    tbl.push_back('{1'b1, 4'ha, 16'h000c, 16'h0});
    tbl.push_back('{1'b0, 4'ha, 16'h0, 16'h000c});
    tbl.push_back('{1'b0, 4'hb, 16'h0, 16'h0});
    tbl.push_back('{1'b1, 4'ha, 16'h0, 16'h0});
    tbl.push_back('{1'b0, 4'ha, 16'h0, 16'h0});
    do_reset();
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].we, tbl[i].a, tbl[i].d);
      if (!tbl[i].we) chk("vec", rd, tbl[i].want);
    end
    // ch0 one-shot with irq: done exactly 20 edges after START
    step(1, 1, 4'h1, 16'd3); step(1, 1, 4'h0, 16'd5); step(1, 1, 4'h2, 16'h9);
    idle(19);
    step(1, 0, 4'h3, 0); chk("ch0_pre_done", rd, 2); chk("ch0_irq_lo", irq, 0);
    step(1, 0, 4'h3, 0); chk("ch0_done", rd, 1); chk("ch0_irq_hi", irq, 1);
    step(1, 0, 4'h4, 0); chk("ch0_count", rd, 5);
    step(1, 1, 4'h3, 16'h1);
    idle(1); chk("ch0_irq_clr", irq, 0);
    step(1, 0, 4'h3, 0); chk("ch0_cleared", rd, 0);
    // ch1 periodic without irq
    step(1, 1, 4'h9, 16'd1); step(1, 1, 4'h8, 16'd3); step(1, 1, 4'ha, 16'h5);
    idle(5);
    step(1, 0, 4'hb, 0); chk("ch1_pre", rd, 2);
    step(1, 0, 4'hb, 0); chk("ch1_done1", rd, 3);
    step(1, 1, 4'hb, 16'h1);
    step(1, 0, 4'hb, 0); chk("ch1_clr", rd, 2);
    idle(2);
    step(1, 0, 4'hb, 0); chk("ch1_pre2", rd, 2);
    step(1, 0, 4'hb, 0); chk("ch1_done2", rd, 3);
    for (int i = 0; i < 8; i++) step(1, 0, 4'hc, 0);
    chk("ch1_noirq", irq, 0);
    // ch0 restart mid-count while ch1 keeps running
    step(1, 1, 4'hb, 16'h1);
    step(1, 1, 4'h2, 16'h9);
    idle(6);
    step(1, 1, 4'h2, 16'h9);
    for (int i = 0; i < 19; i++) begin
      step(1, 0, 4'h3, 0); chk("ch0_restart_hold", rd, 2);
    end
    step(1, 0, 4'h3, 0); chk("ch0_restart_pre", rd, 2);
    step(1, 0, 4'h3, 0); chk("ch0_restart_done", rd, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 4'hc, 0);
    step(1, 1, 4'ha, 16'h2);
    step(1, 1, 4'hb, 16'h1);
    // ROUNDS_GOAL = 0 completes on the START edge
    step(1, 1, 4'h0, 16'd0); step(1, 1, 4'h2, 16'h1);
    step(1, 0, 4'h3, 0); chk("r0_done", rd, 1);
    // goal write mid-run freezes COUNT
    step(1, 1, 4'h0, 16'd10); step(1, 1, 4'h1, 16'd0); step(1, 1, 4'h2, 16'h1);
    idle(3);
    step(1, 1, 4'h0, 16'd10);
    step(1, 0, 4'h4, 0); chk("gw_count", rd, 4);
    idle(2);
    step(1, 0, 4'h4, 0); chk("gw_frozen", rd, 4);
    step(1, 0, 4'h3, 0); chk("gw_status", rd, 0);
    // done set beats same-edge W1C
    step(1, 1, 4'h0, 16'd2); step(1, 1, 4'h2, 16'h1);
    idle(1);
    step(1, 1, 4'h3, 16'h1);
    step(1, 0, 4'h3, 0); chk("set_beats_clr", rd, 1);
    // goal write on a periodic completion edge: stops, done still set
    step(1, 1, 4'h2, 16'h5);
    idle(1);
    step(1, 1, 4'h1, 16'd0);
    step(1, 0, 4'h3, 0); chk("gw_done", rd, 1);
    step(1, 0, 4'h4, 0); chk("gw_wrap", rd, 0);
    // START wins over STOP, then STOP freezes
    step(1, 1, 4'h0, 16'd5); step(1, 1, 4'h2, 16'h3);
    step(1, 0, 4'h3, 0); chk("start_wins", rd, 2);
    step(1, 1, 4'h2, 16'h2);
    step(1, 0, 4'h4, 0); chk("stop_count", rd, 1);
    idle(2);
    step(1, 0, 4'h4, 0); chk("stop_frozen", rd, 1);
    step(1, 0, 4'h3, 0); chk("stop_status", rd, 0);
    // reset in the middle of an irq-enabled one-shot
    step(1, 1, 4'h1, 16'd3); step(1, 1, 4'h0, 16'd5); step(1, 1, 4'h2, 16'h9);
    idle(9);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 4'h3, 0); chk("rst_status", rd, 0); chk("rst_irq", irq, 0);
    end
    step(1, 0, 4'h4, 0); chk("rst_count", rd, 0);
    // random traffic against the model
    for (int k = 0; k < 2; k++) begin
      step(1, 1, {k[0], 3'd0}, 16'd3);
      step(1, 1, {k[0], 3'd1}, 16'd1);
    end
    for (int i = 0; i < 900; i++) begin
      kb = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 11));
      case (op)
        0: step(1, 1, {kb, 3'd0}, 16'($urandom_range(0, 6)));
        1: step(1, 1, {kb, 3'd1}, 16'($urandom_range(0, 3)));
        2, 3: step(1, 1, {kb, 3'd2}, 16'($urandom));
        4: step(1, 1, {kb, 3'd3}, 16'($urandom_range(0, 1)));
        9: step(1, 1, {kb, 3'($urandom_range(4, 7))}, 16'($urandom));
        10, 11: idle(1);
        default: step(1, 0, {kb, 3'($urandom_range(0, 7))}, 16'h0);
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
